// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared types and constants for the I2C register target.
//   state_t      - protocol FSM states
//   SYNC_STAGES  - synchronizer depth on the raw SCL/SDA pins
//   BYTE_W       - bits per I2C byte
//   ACK_LVL/NACK_LVL - SDA levels of an acknowledge / not-acknowledge
package i2c_target_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BYTE_W      = 8;
    localparam logic        ACK_LVL     = 1'b0;
    localparam logic        NACK_LVL    = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: conditions the raw I2C pins for the system-clock domain.
//   clk, reset        - system clock, synchronous active-high reset
//   scl_i, sda_i      - raw pin levels
//   scl_rise/scl_fall - one-cycle strobes on synchronized SCL edges
//   start_det         - SDA fell while SCL stayed high
//   stop_det          - SDA rose while SCL stayed high
//   sda_s             - synchronized SDA level
module i2c_line_sync
    import i2c_target_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a 2^AW x 8-bit register file.
// The first written byte sets the register pointer; further bytes write or
// read sequential registers. SCL/SDA are oversampled on clk.
//   clk, reset  - system clock (>= 20x SCL), synchronous active-high reset
//   scl_i/sda_i - raw pin levels
//   sda_oe      - 1 pulls SDA low (open drain)
//   reg_addr    - register pointer
//   reg_wdata   - write data, valid with reg_we
//   reg_we      - one-cycle write strobe at reg_addr
//   reg_re      - one-cycle read request at reg_addr
//   reg_rdata   - read data, sampled the cycle after reg_re
//   addressed   - high from own-address ACK until STOP/START
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR = 7'h21,
    parameter int unsigned AW       = 5,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          addressed
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0] shreg, shreg_n;
    logic              sda_oe_n;
    logic [AW-1:0]     reg_addr_n;
    logic [7:0]        reg_wdata_n;
    logic              reg_we_n, reg_re_n, addressed_n;
    logic              rd_cap;
    logic [BYTE_W-1:0] shift_in;
    logic              byte_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            addressed <= 1'b0;
            rd_cap    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
            addressed <= addressed_n;
            rd_cap    <= reg_re;   // reg_rdata is valid the cycle after reg_re
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        sda_oe_n    = sda_oe;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;
        addressed_n = addressed;
        shift_in    = {shreg[BYTE_W-2:0], sda_s};
        byte_done   = scl_rise && (bit_cnt == 4'(BYTE_W - 1));

        // Write pointer advances the cycle after the strobe so the strobe
        // itself is seen at the address it targets.
        if (reg_we && AUTO_INC)
            reg_addr_n = reg_addr + 1'b1;

        if (stop_det) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            addressed_n = 1'b0;
        end else if (start_det) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            sda_oe_n    = 1'b0;
            addressed_n = 1'b0;
        end else begin
            unique case (state)
                ADDR, PTR, WR: begin
                    if (scl_rise) begin
                        shreg_n   = shift_in;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                    if (byte_done) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift_in[BYTE_W-1:1] == I2C_ADDR) begin
                                state_n     = ADDR_ACK;
                                addressed_n = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end else if (state == PTR) begin
                            reg_addr_n = shift_in[AW-1:0];
                            state_n    = PTR_ACK;
                        end else begin
                            reg_wdata_n = shift_in;
                            reg_we_n    = 1'b1;
                            state_n     = WR_ACK;
                        end
                    end
                end
                // First falling edge starts driving the ACK, the second ends it;
                // sda_oe itself tells the two apart.
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = ~ACK_LVL;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && shreg[0]) begin
                                reg_re_n = 1'b1;
                                state_n  = RD;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (rd_cap) begin
                        shreg_n   = reg_rdata;
                        sda_oe_n  = ~reg_rdata[BYTE_W-1];
                        bit_cnt_n = '0;
                    end else begin
                        if (scl_rise)
                            bit_cnt_n = bit_cnt + 1'b1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'(BYTE_W)) begin
                                sda_oe_n  = 1'b0;
                                bit_cnt_n = '0;
                                state_n   = RD_ACK;
                                if (AUTO_INC)
                                    reg_addr_n = reg_addr + 1'b1;
                            end else begin
                                shreg_n  = {shreg[BYTE_W-2:0], 1'b0};
                                sda_oe_n = ~shreg[BYTE_W-2];
                            end
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise)
                        shreg_n = shift_in;
                    if (scl_fall) begin
                        if (shreg[0] == NACK_LVL) begin
                            state_n = IGNORE;
                        end else begin
                            reg_re_n = 1'b1;
                            state_n  = RD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: an I2C initiator model drives the
// open-drain bus, expected register strobes are queued as stimulus is issued
// and a monitor pops/compares them whenever reg_we or reg_re fires.
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int Q = 20;  // clk cycles per SCL half period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m, sda_line;
    logic       sda_oe, reg_we, reg_re, addressed;
    logic [4:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata, rdata_q;

    typedef struct {
        bit         is_we;
        logic [4:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  oe_cnt = 0;
    int  ad_cnt = 0;

    always #5 clk = ~clk;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = rdata_q;

    i2c_target_regs #(
        .I2C_ADDR (7'h21),
        .AW       (5),
        .AUTO_INC (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .addressed (addressed)
    );

    // Register file model: value 0x10+addr, presented only on the cycle after reg_re.
    initial begin
        rdata_q = 8'hEE;
        forever begin
            @(posedge clk);
            rdata_q <= reg_re ? (8'h10 + {3'b000, reg_addr}) : 8'hEE;
        end
    end

    // Strobe monitor / scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (sda_oe)    oe_cnt = oe_cnt + 1;
            if (addressed) ad_cnt = ad_cnt + 1;
            if (reg_we || reg_re) begin
                total = total + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_strobe got we=%0b re=%0b addr=%h data=%h want none",
                             reg_we, reg_re, reg_addr, reg_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_we != e.is_we || reg_re == e.is_we || reg_addr != e.addr ||
                        (e.is_we && reg_wdata != e.data)) begin
                        bad = bad + 1;
                        $display("FAIL strobe got we=%0b re=%0b addr=%h data=%h want we=%0b addr=%h data=%h",
                                 reg_we, reg_re, reg_addr, reg_wdata, e.is_we, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_we(input logic [4:0] a, input logic [7:0] d);
        ev_t e;
        e.is_we = 1'b1; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_re(input logic [4:0] a);
        ev_t e;
        e.is_we = 1'b0; e.addr = a; e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        wait_clk(2);  sda_m = 1'b1;
        wait_clk(Q-2); scl_m = 1'b1;
        wait_clk(Q);  sda_m = 1'b0;
        wait_clk(Q);  scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(2);  sda_m = 1'b0;
        wait_clk(Q-2); scl_m = 1'b1;
        wait_clk(Q);  sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(2);  sda_m = b;
        wait_clk(Q-2); scl_m = 1'b1;
        wait_clk(Q);  scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(2);  sda_m = 1'b1;
        wait_clk(Q-2); scl_m = 1'b1;
        wait_clk(Q/2); b = sda_line;
        wait_clk(Q/2); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         oe0, ad0;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        check("rst_sda_oe",    32'(sda_oe),    32'h0);
        check("rst_reg_we",    32'(reg_we),    32'h0);
        check("rst_reg_re",    32'(reg_re),    32'h0);
        check("rst_addressed", 32'(addressed), 32'h0);
        check("rst_reg_addr",  32'(reg_addr),  32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        reset = 1'b0;
        wait_clk(5);

        // Pointer write with auto-increment
        push_we(5'h03, 8'hA5);
        push_we(5'h04, 8'h5A);
        i2c_start();
        write_byte(8'h42, ack); check("t1_ack_addr", 32'(ack), 32'h1);
        check("t1_addressed", 32'(addressed), 32'h1);
        write_byte(8'h03, ack); check("t1_ack_ptr", 32'(ack), 32'h1);
        write_byte(8'hA5, ack); check("t1_ack_d0", 32'(ack), 32'h1);
        write_byte(8'h5A, ack); check("t1_ack_d1", 32'(ack), 32'h1);
        i2c_stop();
        wait_clk(10);
        check("t1_reg_addr",  32'(reg_addr),  32'h05);
        check("t1_addressed_after_stop", 32'(addressed), 32'h0);

        // Random read via repeated START
        push_re(5'h10);
        push_re(5'h11);
        i2c_start();
        write_byte(8'h42, ack); check("t2_ack_addr_w", 32'(ack), 32'h1);
        write_byte(8'h10, ack); check("t2_ack_ptr", 32'(ack), 32'h1);
        i2c_start();
        write_byte(8'h43, ack); check("t2_ack_addr_r", 32'(ack), 32'h1);
        read_byte(d, 1'b1); check("t2_rd0", 32'(d), 32'h20);
        read_byte(d, 1'b0); check("t2_rd1", 32'(d), 32'h21);
        wait_clk(6);
        check("t2_sda_released", 32'(sda_oe), 32'h0);
        i2c_stop();
        wait_clk(10);
        check("t2_addressed", 32'(addressed), 32'h0);
        check("t2_reg_addr",  32'(reg_addr),  32'h12);

        // Wrong address: target must stay silent
        oe0 = oe_cnt; ad0 = ad_cnt;
        i2c_start();
        write_byte(8'h40, ack); check("t3_nack_addr", 32'(ack), 32'h0);
        write_byte(8'hFF, ack); check("t3_nack_data", 32'(ack), 32'h0);
        i2c_stop();
        wait_clk(10);
        check("t3_oe_cycles",        32'(oe_cnt - oe0), 32'h0);
        check("t3_addressed_cycles", 32'(ad_cnt - ad0), 32'h0);

        // Pointer wrap-around
        push_we(5'h1F, 8'h11);
        push_we(5'h00, 8'h22);
        i2c_start();
        write_byte(8'h42, ack); check("t4_ack_addr", 32'(ack), 32'h1);
        write_byte(8'h1F, ack); check("t4_ack_ptr", 32'(ack), 32'h1);
        write_byte(8'h11, ack); check("t4_ack_d0", 32'(ack), 32'h1);
        write_byte(8'h22, ack); check("t4_ack_d1", 32'(ack), 32'h1);
        i2c_stop();
        wait_clk(10);
        check("t4_reg_addr", 32'(reg_addr), 32'h01);

        // STOP after 5 data bits: no write, pointer kept
        i2c_start();
        write_byte(8'h42, ack); check("t6_ack_addr", 32'(ack), 32'h1);
        write_byte(8'h0A, ack); check("t6_ack_ptr", 32'(ack), 32'h1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        check("t6_addressed_mid", 32'(addressed), 32'h1);
        i2c_stop();
        wait_clk(10);
        check("t6_addressed", 32'(addressed), 32'h0);
        check("t6_state",     32'(dut.state), 32'(IDLE));
        check("t6_reg_addr",  32'(reg_addr),  32'h0A);

        // Reset during 4th bit of a read byte (0x20: 4th bit is 0, SDA driven)
        push_re(5'h10);
        i2c_start();
        write_byte(8'h42, ack); check("t5_ack_addr_w", 32'(ack), 32'h1);
        write_byte(8'h10, ack); check("t5_ack_ptr", 32'(ack), 32'h1);
        i2c_start();
        write_byte(8'h43, ack); check("t5_ack_addr_r", 32'(ack), 32'h1);
        for (int i = 0; i < 3; i++) read_bit(b);
        wait_clk(2);   sda_m = 1'b1;
        wait_clk(Q-2); scl_m = 1'b1;
        wait_clk(Q/2);
        check("t5_oe_before_reset", 32'(sda_oe), 32'h1);
        reset = 1'b1;
        wait_clk(1);
        check("t5_oe_after_reset", 32'(sda_oe),    32'h0);
        check("t5_state",          32'(dut.state), 32'(IDLE));
        check("t5_reg_addr",       32'(reg_addr),  32'h00);
        check("t5_addressed",      32'(addressed), 32'h0);
        reset = 1'b0;
        wait_clk(Q/2); scl_m = 1'b0;
        i2c_stop();
        push_we(5'h07, 8'h3C);
        i2c_start();
        write_byte(8'h42, ack); check("t5w_ack_addr", 32'(ack), 32'h1);
        write_byte(8'h07, ack); check("t5w_ack_ptr", 32'(ack), 32'h1);
        write_byte(8'h3C, ack); check("t5w_ack_d0", 32'(ack), 32'h1);
        i2c_stop();
        wait_clk(10);
        check("t5w_reg_addr", 32'(reg_addr), 32'h08);

        wait_clk(20);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
